data_ram_arbiter: RTL
=====================

# data_ram_arbiter

Shares the CPU's single-port 1024x32 data RAM between two requesters: the CPU load/store path (port 0) and a debug/program-loader port (port 1). Each cycle it grants at most one request, using round-robin priority. It steers the address, write data and enable to the RAM and routes the synchronous read data back to the requester that issued the read. It also drives the CPU stall, supports a debug bus lock for burst access, and counts CPU stall cycles. It sits between the CPU datapath's ALU-address/RAM-result path and the RAM macro.

## Interface
- ADDR_W, 10, RAM word address width
- DATA_W, 32, RAM data width
- STALL_CNT_W, 16, width of saturating stall counter

- MAX10_CLK1_50  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- cpu_req / cpu_we  in  1 / 1  CPU access request / write (1) or read (0)
- cpu_addr / cpu_wdata  in  ADDR_W / DATA_W  CPU address / write data
- cpu_gnt  out  1  CPU request accepted this cycle
- cpu_rvalid / cpu_rdata  out  1 / DATA_W  CPU read data valid / value
- cpu_stall  out  1  cpu_req & ~cpu_gnt
- dbg_req / dbg_we / dbg_lock  in  1 / 1 / 1  debug request / write / exclusive-lock request
- dbg_addr / dbg_wdata  in  ADDR_W / DATA_W  debug address / write data
- dbg_gnt  out  1  debug request accepted this cycle
- dbg_rvalid / dbg_rdata  out  1 / DATA_W  debug read data valid / value
- ram_en / ram_we  out  1 / 1  RAM access enable / write enable
- ram_addr / ram_wdata  out  ADDR_W / DATA_W  RAM address / write data
- ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read-enable
- locked  out  1  arbiter in LOCKED state
- stall_count  out  STALL_CNT_W  saturating count of cycles with cpu_stall=1

## Operation
- Requester contract: req, we, addr and wdata are held stable while req=1 and gnt=0. A transaction completes on any cycle where req=1 and gnt=1. A requester may re-request in the very next cycle.
- Registered state:
  - FSM: ARB or LOCKED
  - prio pointer: 0=CPU, 1=debug
  - rd_pend and rd_owner
  - stall_count
- ARB state:
  - Only one requester asserting req: that requester is granted.
  - Both asserting req: the requester selected by prio is granted.
  - After any grant, prio moves to the other port.
- LOCKED state:
  - Only dbg_req can be granted. cpu_gnt=0.
  - prio is frozen.
- Transitions:
  - ARB -> LOCKED: on a cycle with dbg_gnt=1 and dbg_lock=1.
  - LOCKED -> ARB: on a cycle with dbg_lock=0. On exit, prio is set to 0 (CPU).
  - dbg_req is not required for the LOCKED -> ARB transition.
- RAM steering:
  - ram_en = cpu_gnt | dbg_gnt.
  - ram_we, ram_addr and ram_wdata are muxed from the granted port.
  - With no grant: ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0.
- Read return:
  - A granted read sets rd_pend=1 and rd_owner=granted port for the next cycle.
  - In that next cycle, the owner's rvalid=1 and its rdata=ram_rdata.
  - The non-owner's rdata=0.
  - Writes never produce rvalid.
- Back-to-back grants are allowed every cycle, so read returns are pipelined. A read return and a new grant in the same cycle are legal.
- stall_count increments on each cycle with cpu_stall=1. It saturates at all-ones.

## Timing
- gnt, ram_* and cpu_stall are combinational from the req inputs and registered state, with zero-cycle grant latency.
- Read latency: rvalid is asserted exactly 1 cycle after the granting cycle.
- Reset values:
  - FSM=ARB, prio=0, rd_pend=0, stall_count=0.
  - All outputs 0 while reset=1: cpu_gnt, dbg_gnt, rvalids, rdatas, ram_*, cpu_stall, locked.
  - While reset=1, no grant is issued even if req=1.
- Reset mid-operation: a pending read return is dropped, so rvalid=0 in the cycle after reset. LOCKED is exited immediately.
- Simultaneous dbg_gnt and dbg_lock deassertion in LOCKED: the grant is honored. The next cycle is ARB with prio=0.
- stall_count at all-ones with cpu_stall=1: holds its value.

## Test plan
- Single read: after reset, dbg writes 0xDEADBEEF to addr 0x3FF (dbg_gnt same cycle). CPU then reads 0x3FF -> cpu_gnt=1 and ram_addr=0x3FF in the request cycle; next cycle cpu_rvalid=1, cpu_rdata=0xDEADBEEF, dbg_rvalid=0.
- Contention: cpu_req and dbg_req held high for 4 cycles from reset -> grants alternate CPU, dbg, CPU, dbg; cpu_stall=1 on cycles 2 and 4; stall_count=2.
- Pipelined reads: CPU reads addr 1, 2, 3 on consecutive cycles, RAM preloaded 0x11, 0x22, 0x33 -> cpu_rvalid high 3 consecutive cycles with 0x11, 0x22, 0x33.
- Lock burst: dbg_lock=1 with 3 dbg writes while cpu_req=1 -> cpu_gnt=0 for all 3 cycles, locked=1. Drop dbg_lock -> the next cycle is ARB and cpu_gnt=1.
- Reset mid-read: CPU read granted, reset=1 the next cycle -> cpu_rvalid=0, stall_count=0, locked=0.
- Saturation: with STALL_CNT_W=4, hold dbg_lock and cpu_req for 20 cycles -> stall_count stops at 15.

Source files
------------

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between the CPU (port 0)
// and a debug/loader port (port 1), with debug bus lock and saturating CPU stall counter.
module data_ram_arbiter #(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   MAX10_CLK1_50,
    input  logic                   reset,
    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic [DATA_W-1:0]      cpu_rdata,
    output logic                   cpu_stall,
    input  logic                   dbg_req,
    input  logic                   dbg_we,
    input  logic                   dbg_lock,
    input  logic [ADDR_W-1:0]      dbg_addr,
    input  logic [DATA_W-1:0]      dbg_wdata,
    output logic                   dbg_gnt,
    output logic                   dbg_rvalid,
    output logic [DATA_W-1:0]      dbg_rdata,
    output logic                   ram_en,
    output logic                   ram_we,
    output logic [ADDR_W-1:0]      ram_addr,
    output logic [DATA_W-1:0]      ram_wdata,
    input  logic [DATA_W-1:0]      ram_rdata,
    output logic                   locked,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic {ARB, LOCKED} state_t;

    state_t                 state_q, state_d;
    logic                   prio_q, prio_d;          // 0: CPU wins a tie, 1: debug wins
    logic                   rd_pend_q, rd_pend_d;
    logic                   rd_owner_q, rd_owner_d;  // 0: CPU, 1: debug
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state_q     <= ARB;
            prio_q      <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_owner_q  <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            prio_q      <= prio_d;
            rd_pend_q   <= rd_pend_d;
            rd_owner_q  <= rd_owner_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Grant decision and FSM; all grants are suppressed while reset is high.
    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!reset) begin
            case (state_q)
                ARB: begin
                    if (cpu_req && dbg_req) begin
                        cpu_gnt = ~prio_q;
                        dbg_gnt = prio_q;
                    end else begin
                        cpu_gnt = cpu_req;
                        dbg_gnt = dbg_req;
                    end
                    if (cpu_gnt) begin
                        prio_d = 1'b1;
                    end else if (dbg_gnt) begin
                        prio_d = 1'b0;
                    end
                    if (dbg_gnt && dbg_lock) begin
                        state_d = LOCKED;
                    end
                end
                LOCKED: begin
                    dbg_gnt = dbg_req;
                    if (!dbg_lock) begin
                        state_d = ARB;
                        prio_d  = 1'b0;
                    end
                end
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (cpu_gnt) begin
            ram_en    = 1'b1;
            ram_we    = cpu_we;
            ram_addr  = cpu_addr;
            ram_wdata = cpu_wdata;
        end else if (dbg_gnt) begin
            ram_en    = 1'b1;
            ram_we    = dbg_we;
            ram_addr  = dbg_addr;
            ram_wdata = dbg_wdata;
        end
    end

    always_comb begin
        rd_pend_d  = ram_en && !ram_we;
        rd_owner_d = dbg_gnt;
    end

    always_comb begin
        cpu_rvalid = !reset && rd_pend_q && !rd_owner_q;
        dbg_rvalid = !reset && rd_pend_q && rd_owner_q;
        cpu_rdata  = cpu_rvalid ? ram_rdata : '0;
        dbg_rdata  = dbg_rvalid ? ram_rdata : '0;
    end

    always_comb begin
        cpu_stall   = !reset && cpu_req && !cpu_gnt;
        stall_cnt_d = stall_cnt_q;
        if (cpu_stall && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    assign locked      = !reset && (state_q == LOCKED);
    assign stall_count = stall_cnt_q;

endmodule
